// File: rtl/pcie_8b10b_pkg.sv
// Shared 8b/10b definitions: the 5b/6b code table, K.28 codewords and the
// classification record produced by the 6b reverse lookup.
package pcie_8b10b_pkg;

   // Codewords are written abcdei, so bit5 = a (first on the wire).
   localparam logic [5:0] CODE_6B_RDN [32] = '{
      6'b100111, 6'b011101, 6'b101101, 6'b110001,
      6'b110101, 6'b101001, 6'b011001, 6'b111000,
      6'b111001, 6'b100101, 6'b010101, 6'b110100,
      6'b001101, 6'b101100, 6'b011100, 6'b010111,
      6'b011011, 6'b100011, 6'b010011, 6'b110010,
      6'b001011, 6'b101010, 6'b011010, 6'b111010,
      6'b110011, 6'b100110, 6'b010110, 6'b110110,
      6'b001110, 6'b101110, 6'b011110, 6'b101011
   };

   localparam logic [5:0] CODE_6B_RDP [32] = '{
      6'b011000, 6'b100010, 6'b010010, 6'b110001,
      6'b001010, 6'b101001, 6'b011001, 6'b000111,
      6'b000110, 6'b100101, 6'b010101, 6'b110100,
      6'b001101, 6'b101100, 6'b011100, 6'b101000,
      6'b100100, 6'b100011, 6'b010011, 6'b110010,
      6'b001011, 6'b101010, 6'b011010, 6'b000101,
      6'b001100, 6'b100110, 6'b010110, 6'b001001,
      6'b001110, 6'b010001, 6'b100001, 6'b010100
   };

   localparam logic [5:0] K28_6B_RDN = 6'b001111;
   localparam logic [5:0] K28_6B_RDP = 6'b110000;
   localparam logic [5:0] D07_6B_RDN = 6'b111000;
   localparam logic [5:0] D07_6B_RDP = 6'b000111;

   typedef struct packed {
      logic [4:0] value;
      logic       is_k;
      logic       code_err;
      logic       is_neutral;
      logic       is_balanced_special;
      logic [2:0] weight;
   } sixb_class_t;

endpackage

// File: rtl/decoder_6b5b_sixb_classify.sv
// Combinational 6b reverse lookup: decoded value, K.28 flag, table membership
// and word weight. RD-independent; disparity checks live with the caller.
module sixb_classify
   import pcie_8b10b_pkg::*;
(
   input  logic [5:0]  data_i,
   output sixb_class_t cls_o
);

   logic found;

   always_comb begin
      cls_o = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < 6; i++) begin
         cls_o.weight = cls_o.weight + 3'(data_i[i]);
      end
      for (int unsigned i = 0; i < 32; i++) begin
         if (data_i == CODE_6B_RDN[i] || data_i == CODE_6B_RDP[i]) begin
            cls_o.value = 5'(i);
            found       = 1'b1;
         end
      end
      if (data_i == K28_6B_RDN || data_i == K28_6B_RDP) begin
         cls_o.value = 5'd28;
         cls_o.is_k  = 1'b1;
         found       = 1'b1;
      end
      cls_o.code_err            = ~found;
      cls_o.is_neutral          = found && (cls_o.weight == 3'd3);
      cls_o.is_balanced_special = (data_i == D07_6B_RDN) || (data_i == D07_6B_RDP);
   end

endmodule

// File: rtl/decoder_6b5b.sv
// 6b/5b receive sub-block decoder with running-disparity tracking, code and
// disparity error flags and a saturating error counter.
module decoder_6b5b
   import pcie_8b10b_pkg::*;
#(
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 valid_i,
   input  logic [5:0]           data_i,
   input  logic                 rd_force_neg_i,
   input  logic                 err_cnt_clr_i,
   output logic                 valid_o,
   output logic [4:0]           data_o,
   output logic                 is_k28_o,
   output logic                 code_err_o,
   output logic                 disp_err_o,
   output logic                 rd_neg_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o
);

   sixb_class_t          cls;
   logic                 rd_eff_neg;
   logic                 word_err;

   logic                 valid_q, valid_d;
   logic [4:0]           data_q, data_d;
   logic                 k28_q, k28_d;
   logic                 cerr_q, cerr_d;
   logic                 derr_q, derr_d;
   logic                 rd_neg_q, rd_neg_d;
   logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

   sixb_classify u_classify (
      .data_i (data_i),
      .cls_o  (cls)
   );

   assign rd_eff_neg = rd_force_neg_i | rd_neg_q;

   always_comb begin
      valid_d  = valid_i;
      data_d   = data_q;
      k28_d    = 1'b0;
      cerr_d   = 1'b0;
      derr_d   = 1'b0;
      rd_neg_d = rd_neg_q;
      cnt_d    = cnt_q;
      word_err = 1'b0;

      if (valid_i) begin
         rd_neg_d = rd_eff_neg;
         if (cls.code_err) begin
            cerr_d = 1'b1;
            data_d = '0;
         end else begin
            data_d = cls.value;
            k28_d  = cls.is_k;
            if (cls.is_balanced_special) begin
               // 111000 belongs to RD-, 000111 to RD+; neither moves RD.
               derr_d = (data_i == D07_6B_RDN) ? ~rd_eff_neg : rd_eff_neg;
            end else if (cls.weight == 3'd4) begin
               derr_d   = ~rd_eff_neg;
               rd_neg_d = 1'b0;
            end else if (cls.weight == 3'd2) begin
               derr_d   = rd_eff_neg;
               rd_neg_d = 1'b1;
            end
         end
         word_err = cerr_d | derr_d;
      end

      if (err_cnt_clr_i) begin
         cnt_d = ERR_CNT_W'(word_err);
      end else if (word_err && cnt_q != '1) begin
         cnt_d = cnt_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q  <= 1'b0;
         data_q   <= '0;
         k28_q    <= 1'b0;
         cerr_q   <= 1'b0;
         derr_q   <= 1'b0;
         rd_neg_q <= 1'b1;
         cnt_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         data_q   <= data_d;
         k28_q    <= k28_d;
         cerr_q   <= cerr_d;
         derr_q   <= derr_d;
         rd_neg_q <= rd_neg_d;
         cnt_q    <= cnt_d;
      end
   end

   assign valid_o    = valid_q;
   assign data_o     = data_q;
   assign is_k28_o   = k28_q;
   assign code_err_o = cerr_q;
   assign disp_err_o = derr_q;
   assign rd_neg_o   = rd_neg_q;
   assign err_cnt_o  = cnt_q;

endmodule

// File: tb/tb_decoder_6b5b.sv
// Directed plus randomized bench for decoder_6b5b against a table-driven
// reference that derives RD+ codewords by complementing unbalanced RD- words.
module tb_decoder_6b5b;

   localparam int unsigned CW = 2;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          valid_i;
   logic [5:0]    data_i;
   logic          rd_force_neg_i;
   logic          err_cnt_clr_i;
   logic          valid_o;
   logic [4:0]    data_o;
   logic          is_k28_o;
   logic          code_err_o;
   logic          disp_err_o;
   logic          rd_neg_o;
   logic [CW-1:0] err_cnt_o;

   int checks = 0;
   int errors = 0;

   // Reference state
   logic          m_valid, m_k, m_cerr, m_derr, m_rdneg;
   logic [4:0]    m_data;
   int            m_cnt;

   logic [5:0] rdn_list [32] = '{
      6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
      6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
      6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
      6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
      6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
      6'b011110, 6'b101011
   };

   decoder_6b5b #(.ERR_CNT_W(CW)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .valid_i        (valid_i),
      .data_i         (data_i),
      .rd_force_neg_i (rd_force_neg_i),
      .err_cnt_clr_i  (err_cnt_clr_i),
      .valid_o        (valid_o),
      .data_o         (data_o),
      .is_k28_o       (is_k28_o),
      .code_err_o     (code_err_o),
      .disp_err_o     (disp_err_o),
      .rd_neg_o       (rd_neg_o),
      .err_cnt_o      (err_cnt_o)
   );

   always #5 clk = ~clk;

   // Index 32 stands for K.28. RD+ form = complement unless the word is
   // balanced, with D.07 the one balanced word that still alternates.
   function automatic logic [5:0] word_of(input int i, input bit plus);
      logic [5:0] m;
      m = (i == 32) ? 6'b001111 : rdn_list[i];
      if (plus && ($countones(m) != 3 || i == 7)) return ~m;
      return m;
   endfunction

   task automatic model_word(input logic [5:0] w, input logic rdn_eff,
                             output logic [4:0] val, output logic k,
                             output logic cerr, output logic derr,
                             output logic newrdn);
      logic lm, lp;
      lm = 1'b0; lp = 1'b0; val = '0; k = 1'b0;
      for (int i = 0; i < 33; i++) begin
         if (w == word_of(i, 1'b0) || w == word_of(i, 1'b1)) begin
            val = (i == 32) ? 5'd28 : 5'(i);
            k   = (i == 32);
            if (w == word_of(i, 1'b0)) lm = 1'b1;
            if (w == word_of(i, 1'b1)) lp = 1'b1;
         end
      end
      cerr   = !(lm || lp);
      derr   = !cerr && (rdn_eff ? !lm : !lp);
      newrdn = rdn_eff;
      if (cerr) begin
         val = '0; k = 1'b0;
      end else if ($countones(w) == 4) begin
         newrdn = 1'b0;
      end else if ($countones(w) == 2) begin
         newrdn = 1'b1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0; m_data = '0; m_k = 1'b0; m_cerr = 1'b0;
      m_derr = 1'b0; m_rdneg = 1'b1; m_cnt = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"}, 32'(valid_o),    32'(m_valid));
      chk({tag, ".data"},  32'(data_o),     32'(m_data));
      chk({tag, ".k28"},   32'(is_k28_o),   32'(m_k));
      chk({tag, ".cerr"},  32'(code_err_o), 32'(m_cerr));
      chk({tag, ".derr"},  32'(disp_err_o), 32'(m_derr));
      chk({tag, ".rdneg"}, 32'(rd_neg_o),   32'(m_rdneg));
      chk({tag, ".cnt"},   32'(err_cnt_o),  32'(m_cnt));
   endtask

   task automatic step(input string tag, input logic v, input logic [5:0] d,
                       input logic f, input logic c);
      logic [4:0] val;
      logic k, ce, de, nr;
      @(negedge clk);
      valid_i = v; data_i = d; rd_force_neg_i = f; err_cnt_clr_i = c;
      @(posedge clk);
      #1;
      m_valid = v;
      if (v) begin
         model_word(d, f ? 1'b1 : m_rdneg, val, k, ce, de, nr);
         m_data = val; m_k = k; m_cerr = ce; m_derr = de; m_rdneg = nr;
      end else begin
         m_k = 1'b0; m_cerr = 1'b0; m_derr = 1'b0;
      end
      if (c) m_cnt = (v && (m_cerr || m_derr)) ? 1 : 0;
      else if (v && (m_cerr || m_derr) && m_cnt < (1 << CW) - 1) m_cnt++;
      check_all(tag);
      valid_i = 1'b0; rd_force_neg_i = 1'b0; err_cnt_clr_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1; valid_i = 1'b0; data_i = '0;
      rd_force_neg_i = 1'b0; err_cnt_clr_i = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      rst_i = 1'b0;

      step("d00m", 1'b1, 6'b100111, 1'b0, 1'b0);
      chk("d00m.rd_pos", 32'(rd_neg_o), 32'd0);
      step("d00p", 1'b1, 6'b011000, 1'b0, 1'b0);
      chk("d00p.rd_neg", 32'(rd_neg_o), 32'd1);
      step("d03", 1'b1, 6'b110001, 1'b0, 1'b0);
      chk("d03.data", 32'(data_o), 32'd3);
      step("d07p_at_neg", 1'b1, 6'b000111, 1'b0, 1'b0);
      chk("d07p.derr", 32'(disp_err_o), 32'd1);
      chk("d07p.data", 32'(data_o), 32'd7);
      chk("d07p.cnt", 32'(err_cnt_o), 32'd1);
      step("w6", 1'b1, 6'b111111, 1'b0, 1'b0);
      chk("w6.cerr", 32'(code_err_o), 32'd1);
      step("w4_bad", 1'b1, 6'b111100, 1'b0, 1'b0);
      chk("w4_bad.cerr", 32'(code_err_o), 32'd1);
      step("k28m", 1'b1, 6'b001111, 1'b0, 1'b0);
      chk("k28m.data", 32'(data_o), 32'd28);
      chk("k28m.rd", 32'(rd_neg_o), 32'd0);
      step("k28p", 1'b1, 6'b110000, 1'b0, 1'b0);
      chk("k28p.k", 32'(is_k28_o), 32'd1);
      step("idle", 1'b0, 6'b000000, 1'b0, 1'b0);
      step("to_pos", 1'b1, 6'b100111, 1'b0, 1'b0);
      step("force", 1'b1, 6'b011101, 1'b1, 1'b0);
      chk("force.data", 32'(data_o), 32'd1);
      chk("force.derr", 32'(disp_err_o), 32'd0);
      chk("force.rd", 32'(rd_neg_o), 32'd0);
      for (int i = 0; i < 5; i++) step("sat", 1'b1, 6'b000000, 1'b0, 1'b0);
      chk("sat.cnt", 32'(err_cnt_o), 32'd3);
      step("clr_err", 1'b1, 6'b111111, 1'b0, 1'b1);
      chk("clr_err.cnt", 32'(err_cnt_o), 32'd1);
      step("clr_only", 1'b0, 6'b000000, 1'b0, 1'b1);
      chk("clr_only.cnt", 32'(err_cnt_o), 32'd0);

      for (int n = 0; n < 400; n++) begin
         logic       v, f, c;
         logic [5:0] d;
         v = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1)
            d = word_of(int'($urandom_range(0, 32)), 1'($urandom_range(0, 1)));
         else
            d = 6'($urandom);
         f = v && ($urandom_range(0, 7) == 0);
         c = ($urandom_range(0, 15) == 0);
         step("rand", v, d, f, c);
      end

      // Asynchronous reset in the middle of a word.
      step("pre_rst", 1'b1, 6'b001111, 1'b0, 1'b0);
      @(negedge clk);
      valid_i = 1'b1; data_i = 6'b000000;
      #2;
      rst_i = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      rst_i = 1'b0; valid_i = 1'b0;
      step("post_rst", 1'b1, 6'b011000, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decoder_6b5b.md
Name: decoder_6b5b

Overview:
- Receive-side 6b/5b sub-block decoder for the 8b/10b PCS datapath, and the counterpart of the 5b/6b transmit encoder.
- Takes one 6-bit sub-block per valid cycle and returns the 5-bit value (EDCBA) plus a K.28 flag.
- Tracks running disparity (RD) and flags code violations and disparity errors.
- Keeps a saturating error counter for link-quality monitoring; sits between the symbol aligner and the 4b/3b decoder / PCS receive logic.

Parameters:
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-high.
- valid_i  input  1  data_i holds a sub-block this cycle.
- data_i  input  6  encoded sub-block; bit5 = a (first on the wire), bit0 = i.
- rd_force_neg_i  input  1  synchronous pulse; forces current RD to negative (used on alignment/resync).
- err_cnt_clr_i  input  1  synchronous clear of err_cnt_o.
- valid_o  output  1  registered copy of valid_i.
- data_o  output  5  decoded value; 0 on code error.
- is_k28_o  output  1  the sub-block was K.28 (001111 or 110000).
- code_err_o  output  1  the word is not in the code table for either RD.
- disp_err_o  output  1  the word is legal, but only for the opposite RD.
- rd_neg_o  output  1  current RD; 1 = negative. Reflects the state after the last decoded word.
- err_cnt_o  output  ERR_CNT_W  saturating count of errored words.

Behaviour:
- Reset values: valid_o=0, data_o=0, is_k28_o=0, code_err_o=0, disp_err_o=0, rd_neg_o=1 (RD-), err_cnt_o=0.
- Latency: every output except err_cnt_o updates on the clock edge after valid_i=1. err_cnt_o updates on that same edge.
- When valid_i=0: valid_o=0 next cycle, the other flag outputs clear to 0, and data_o, RD and the counter hold.
- Effective RD for a word: negative if rd_force_neg_i=1 in the same cycle, otherwise the stored RD.
- Code table: the standard 5b/6b table (IEEE 802.3 cl.36) plus K.28. Examples:
  - D.02 = 101101 (RD-) / 010010 (RD+).
  - D.07 = 111000 (RD-) / 000111 (RD+).
- Classification by weight w (number of ones):
  - w in {0,1,5,6}: code_err=1, RD unchanged.
  - Word not present in the table under either RD: code_err=1, RD unchanged.
  - w=3 neutral word (not 111000/000111): decoded, RD unchanged, never disp_err.
  - 111000: legal only at RD-; 000111: legal only at RD+. The opposite RD gives disp_err=1. In all cases data_o=7 and RD unchanged.
  - w=4 table word: legal only at RD-; new RD = RD+. At RD+, disp_err=1, word still decoded, RD set to RD+ (resync to the received word).
  - w=2 table word: legal only at RD+; new RD = RD-. At RD-, disp_err=1, word still decoded, RD set to RD-.
- code_err and disp_err are mutually exclusive.
- is_k28_o=1 only for 001111/110000; data_o=28 for those words. The disparity rules for w=4/w=2 apply to them.
- Error counter:
  - Increments by 1 per valid word with code_err or disp_err (never by 2).
  - Saturates at 2^ERR_CNT_W-1.
  - err_cnt_clr_i together with an errored word gives a counter of 1. err_cnt_clr_i alone gives 0.
- Reset mid-stream: all state returns to reset values immediately (asynchronous). No partial word survives.

Decomposition:
- Package pcie_8b10b_pkg holds:
  - the 5b/6b code table as constant arrays (RD- and RD+ codeword per 5-bit value);
  - K28_6B_RDN / K28_6B_RDP constants;
  - a typedef for the classification result (struct: value, is_k, code_err, is_neutral, is_balanced_special, weight).
- Sub-module sixb_classify: a pure combinational reverse lookup plus weight computation. It is shared with a later 4b3b decoder wrapper.
- The top level holds the RD register, the output registers and the counter.

Test Plan:
- After reset, valid_i=1, data_i=100111 -> next cycle data_o=0, no errors, rd_neg_o=0. Then 011000 -> data_o=0, rd_neg_o=1.
- At RD-, data_i=110001 (D.03) -> data_o=3, rd_neg_o stays 1. Then 000111 -> disp_err_o=1, data_o=7, rd_neg_o=1, err_cnt_o=1.
- data_i=111111 -> code_err_o=1, data_o=0, RD unchanged. data_i=111100 (w=4, not in table) -> code_err_o=1.
- At RD-, data_i=001111 -> is_k28_o=1, data_o=28, rd_neg_o=0. Then 110000 -> is_k28_o=1, rd_neg_o=1.
- At RD+, pulse rd_force_neg_i with data_i=011101 -> no disp_err, data_o=1, rd_neg_o=0.
- ERR_CNT_W=2: drive 5 errored words -> err_cnt_o saturates at 3. Then clr and an error in the same cycle -> err_cnt_o=1.
